data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressable, little-endian data memory for the RV32 pipeline's memory stage.
- Serves loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) selected by funct3.
- Addresses are rebased by BASE_ADDR and wrap modulo memory size.
- Both reads and writes are synchronous to clk; read data is registered and held.

Parameters:
- AWIDTH, 32, address width in bits.
- DWIDTH, 32, data width in bits; fixed at 32 for RV32.
- BASE_ADDR, 32'h01000000, byte address mapped to memory byte 0.
- DEPTH_BYTES, 1048576, memory size in bytes; must be a power of two.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous assert, active-low.
- addr_i  input  AWIDTH  byte address of the access.
- data_i  input  DWIDTH  store data; the low byte/half/word is used per funct3.
- read_en_i  input  1  load request, sampled at posedge.
- write_en_i  input  1  store request, sampled at posedge.
- funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- data_o  output  DWIDTH  registered load result.

Behaviour:
- Offset = (addr_i - BASE_ADDR) mod DEPTH_BYTES, using the low log2(DEPTH_BYTES) bits of the difference. Addresses below BASE_ADDR wrap; no fault is raised.
- Byte k of an access is located at (offset + k) mod DEPTH_BYTES, little-endian. Misaligned accesses are legal and are not split into multiple cycles.
- Reset (rst low):
  - data_o clears to 0 immediately (asynchronous) and stays 0 while rst is low.
  - Writes and reads are suppressed while rst is low.
  - Memory contents are not cleared; power-up contents are undefined (0 in simulation).
- Store, at posedge with rst high and write_en_i high:
  - funct3 000: write data_i[7:0] to 1 byte.
  - funct3 001: write data_i[15:0] to 2 bytes.
  - funct3 010: write data_i[31:0] to 4 bytes.
  - Any other funct3: no memory change.
- Load, at posedge with rst high and read_en_i high, data_o is loaded with:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - 011, 110, 111: 0.
- Read latency: 1 cycle. Address and funct3 are presented before edge N, and data_o is valid just after edge N.
- data_o holds its value on every cycle with read_en_i low, through following idle and write cycles, until the next read or reset.
- Simultaneous read and write in the same cycle: the read returns the pre-write contents (read-before-write). The write still commits.
- Back-to-back store then load to the same address on consecutive edges: the load sees the stored data.
- Unwritten bytes of a partial store keep their prior values.
- No handshake or stall signals; every request completes in the cycle it is sampled.

Test Plan:
- Reset, then SW 0x01000000 <- 0xDEADBEEF, then LW 0x01000000 -> data_o = 0xDEADBEEF one edge after the load; value still held 1 ns after read_en_i drops.
- SH 0x01000004 <- 0x0000A5A5, then LHU -> 0x0000A5A5. SH 0x01000008 <- 0x0000FFFF, then LH -> 0xFFFFFFFF.
- SB 0x0100000C <- 0xAB, then LBU -> 0x000000AB. SB 0x01000010 <- 0xFF, then LB -> 0xFFFFFFFF. SW 0x01000014 <- 0x11223344, SB 0x01000015 <- 0x55, then LW -> 0x11225544.
- SW to +20, +24 and +28 with 0x12345678, 0x9ABCDEF0 and 0xFEDCBA98 back-to-back, then three LWs -> each value returned unchanged.
- Wrap: SW 0x00000100 <- 0xAAAAAAAA, then LW 0x00000100 -> 0xAAAAAAAA. LW 0x01000100 -> 0xAAAAAAAA (same physical offset 0x100).
- Read and write same cycle to a word holding 0x12345678, writing 0xCAFEF00D: data_o = 0x12345678, and a next LW returns 0xCAFEF00D. Assert rst low mid-stream: data_o = 0 without waiting for a clock edge, and memory contents are retained after release.

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the RV32 memory stage.
// Synchronous loads and stores; the load result is registered and held until the next load or reset.
module data_memory #(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h01000000,
    parameter int                DEPTH_BYTES = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              read_en_i,
    input  logic              write_en_i,
    input  logic [2:0]        funct3_i,
    output logic [DWIDTH-1:0] data_o
);

    localparam int OW = $clog2(DEPTH_BYTES);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Handshake: none. A request is accepted on every posedge where its enable is high
    // and rst is high; it completes in that same cycle, so there is no valid/ready pair.

    logic [7:0]        mem [DEPTH_BYTES];
    logic [AWIDTH-1:0] diff;
    logic [OW-1:0]     ofs0, ofs1, ofs2, ofs3;
    logic [7:0]        rb0, rb1, rb2, rb3;
    logic [DWIDTH-1:0] load_val;
    logic              unused_diff_hi;

    // Offset wraps modulo the memory size: only the low OW bits of the rebased address matter.
    assign diff           = addr_i - BASE_ADDR;
    assign ofs0           = diff[OW-1:0];
    assign ofs1           = ofs0 + OW'(1);
    assign ofs2           = ofs0 + OW'(2);
    assign ofs3           = ofs0 + OW'(3);
    assign unused_diff_hi = ^diff[AWIDTH-1:OW];

    assign rb0 = mem[ofs0];
    assign rb1 = mem[ofs1];
    assign rb2 = mem[ofs2];
    assign rb3 = mem[ofs3];

    always_comb begin
        load_val = '0;
        case (funct3_i)
            F3_B:    load_val = {{24{rb0[7]}}, rb0};
            F3_H:    load_val = {{16{rb1[7]}}, rb1, rb0};
            F3_W:    load_val = {rb3, rb2, rb1, rb0};
            F3_BU:   load_val = {24'h0, rb0};
            F3_HU:   load_val = {16'h0, rb1, rb0};
            default: load_val = '0;
        endcase
    end

    // Reads sample the pre-edge array contents, so a same-cycle store is not visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o <= '0;
        end else if (read_en_i) begin
            data_o <= load_val;
        end
    end

    // Contents are never cleared; stores are simply blocked while rst is low.
    always_ff @(posedge clk) begin
        if (rst && write_en_i) begin
            case (funct3_i)
                F3_B: begin
                    mem[ofs0] <= data_i[7:0];
                end
                F3_H: begin
                    mem[ofs0] <= data_i[7:0];
                    mem[ofs1] <= data_i[15:8];
                end
                F3_W: begin
                    mem[ofs0] <= data_i[7:0];
                    mem[ofs1] <= data_i[15:8];
                    mem[ofs2] <= data_i[23:16];
                    mem[ofs3] <= data_i[31:24];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stores, loads of every width, wrap, read-before-write and async reset.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        read_en_i;
    logic        write_en_i;
    logic [2:0]  funct3_i;
    logic [31:0] data_o;

    int vectors   = 0;
    int miscompares = 0;

    data_memory dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .read_en_i  (read_en_i),
        .write_en_i (write_en_i),
        .funct3_i   (funct3_i),
        .data_o     (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp);
        vectors++;
        assert (data_o === exp) else begin
            miscompares++;
            $error("FAIL %s: data_o=%h expected=%h", tag, data_o, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        @(negedge clk);
        addr_i = a; data_i = d; funct3_i = f3;
        write_en_i = 1'b1; read_en_i = 1'b0;
        @(posedge clk);
        #1;
        write_en_i = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] exp, input string tag);
        @(negedge clk);
        addr_i = a; funct3_i = f3;
        read_en_i = 1'b1; write_en_i = 1'b0;
        @(posedge clk);
        #1;
        check(tag, exp);
        read_en_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; addr_i = '0; data_i = '0;
        read_en_i = 1'b0; write_en_i = 1'b0; funct3_i = 3'b010;

        // Reset: a read request while rst is low must not load anything.
        read_en_i = 1'b1; addr_i = 32'h01000000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'h0);
        @(negedge clk);
        read_en_i = 1'b0;
        rst = 1'b1;

        store(32'h01000000, 32'hDEADBEEF, 3'b010);
        load (32'h01000000, 3'b010, 32'hDEADBEEF, "sw_lw");
        #1;
        check("hold_after_read", 32'hDEADBEEF);
        store(32'h01000040, 32'h00000000, 3'b010);
        check("hold_through_write", 32'hDEADBEEF);

        store(32'h01000004, 32'h0000A5A5, 3'b001);
        load (32'h01000004, 3'b101, 32'h0000A5A5, "sh_lhu");
        store(32'h01000008, 32'h0000FFFF, 3'b001);
        load (32'h01000008, 3'b001, 32'hFFFFFFFF, "sh_lh_sign");

        store(32'h0100000C, 32'h000000AB, 3'b000);
        load (32'h0100000C, 3'b100, 32'h000000AB, "sb_lbu");
        store(32'h01000010, 32'h000000FF, 3'b000);
        load (32'h01000010, 3'b000, 32'hFFFFFFFF, "sb_lb_sign");
        store(32'h01000014, 32'h11223344, 3'b010);
        store(32'h01000015, 32'h00000055, 3'b000);
        load (32'h01000014, 3'b010, 32'h11225544, "sb_partial");
        load (32'h01000014, 3'b011, 32'h00000000, "funct3_011_zero");

        store(32'h01000014, 32'h12345678, 3'b010);
        store(32'h01000018, 32'h9ABCDEF0, 3'b010);
        store(32'h0100001C, 32'hFEDCBA98, 3'b010);
        load (32'h01000014, 3'b010, 32'h12345678, "b2b_0");
        load (32'h01000018, 3'b010, 32'h9ABCDEF0, "b2b_1");
        load (32'h0100001C, 3'b010, 32'hFEDCBA98, "b2b_2");

        // An invalid store funct3 must leave memory untouched.
        store(32'h0100001C, 32'h00000000, 3'b011);
        load (32'h0100001C, 3'b010, 32'hFEDCBA98, "store_f3_011_nop");

        store(32'h00000100, 32'hAAAAAAAA, 3'b010);
        load (32'h00000100, 3'b010, 32'hAAAAAAAA, "wrap_below_base");
        load (32'h01000100, 3'b010, 32'hAAAAAAAA, "wrap_alias");

        // Misaligned word straddling the top of memory wraps to byte 0.
        store(32'h010FFFFE, 32'h44332211, 3'b010);
        load (32'h010FFFFE, 3'b010, 32'h44332211, "wrap_top_word");
        load (32'h01000000, 3'b101, 32'h00004433, "wrap_top_low_half");

        // Same-cycle read and write: read returns old data, write still commits.
        @(negedge clk);
        addr_i = 32'h01000014; data_i = 32'hCAFEF00D; funct3_i = 3'b010;
        read_en_i = 1'b1; write_en_i = 1'b1;
        @(posedge clk);
        #1;
        check("rbw_old", 32'h12345678);
        read_en_i = 1'b0; write_en_i = 1'b0;
        load (32'h01000014, 3'b010, 32'hCAFEF00D, "rbw_new");

        // Asynchronous reset away from any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 32'h0);
        addr_i = 32'h01000018; data_i = 32'h0BADF00D; funct3_i = 3'b010;
        write_en_i = 1'b1; read_en_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 32'h0);
        write_en_i = 1'b0; read_en_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load (32'h01000018, 3'b010, 32'h9ABCDEF0, "retain_after_reset");
        load (32'h01000014, 3'b010, 32'hCAFEF00D, "retain_after_reset2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
